// File: rtl/gru_lstm_cell.sv
// Single-unit GRU cell in signed Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH fixed point, fully pipelined, latency 3.
// Define GRU_LSTM_CELL_SAT_EN for saturating narrowing; without it every narrowing keeps the low bits (wrap).
module gru_lstm_cell #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] X,
    input  logic signed [DATA_WIDTH-1:0] h_in,
    input  logic signed [DATA_WIDTH-1:0] Wz,
    input  logic signed [DATA_WIDTH-1:0] Wr,
    input  logic signed [DATA_WIDTH-1:0] Wh,
    input  logic signed [DATA_WIDTH-1:0] Uz,
    input  logic signed [DATA_WIDTH-1:0] Ur,
    input  logic signed [DATA_WIDTH-1:0] Uh,
    input  logic signed [DATA_WIDTH-1:0] bz,
    input  logic signed [DATA_WIDTH-1:0] br,
    input  logic signed [DATA_WIDTH-1:0] bh,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] h_out
);
    localparam int DW     = DATA_WIDTH;
    localparam int WW     = 2 * DW + 2;
    localparam int STAGES = 3;

    typedef logic signed [DW-1:0] dat_t;
    typedef logic signed [DW:0]   ext_t;
    typedef logic signed [WW-1:0] wide_t;

    localparam wide_t MAX_W   = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam wide_t MIN_W   = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam ext_t  ONE_E   = ext_t'(1 << FRACT_WIDTH);
    localparam ext_t  HALF_E  = ext_t'(1 << (FRACT_WIDTH - 1));
    localparam dat_t  ONE     = dat_t'(1 << FRACT_WIDTH);
    localparam dat_t  NEG_ONE = -ONE;

    function automatic ext_t sx(input dat_t v);
        return {v[DW-1], v};
    endfunction

    function automatic dat_t narrow(input wide_t v);
`ifdef GRU_LSTM_CELL_SAT_EN
        if (v > MAX_W) return MAX_W[DW-1:0];
        if (v < MIN_W) return MIN_W[DW-1:0];
`endif
        return v[DW-1:0];
    endfunction

    // Operands are DW+1 wide so the z*(hc-h) product shares this helper.
    function automatic dat_t qmul(input ext_t a, input ext_t b);
        wide_t p;
        p = a * b;
        return narrow(p >>> FRACT_WIDTH);
    endfunction

    function automatic dat_t sum3(input dat_t a, input dat_t b, input dat_t c);
        logic signed [DW+1:0] s;
        s = {{2{a[DW-1]}}, a} + {{2{b[DW-1]}}, b} + {{2{c[DW-1]}}, c};
        return narrow({{(WW-DW-2){s[DW+1]}}, s});
    endfunction

    function automatic dat_t hsig(input dat_t x);
        ext_t s;
        s = sx(x >>> 2) + HALF_E;
        if (s[DW])     return '0;
        if (s > ONE_E) return ONE;
        return s[DW-1:0];
    endfunction

    function automatic dat_t htanh(input dat_t x);
        if (x > ONE)     return ONE;
        if (x < NEG_ONE) return NEG_ONE;
        return x;
    endfunction

    logic [STAGES:0] vld_pipe_q;
    dat_t z1_q, r1_q, wx1_q, h1_q, uh1_q, bh1_q;
    dat_t z2_q, hc2_q, h2_q;
    dat_t dz3_q, h3_q;
    dat_t h_out_q;

    dat_t z1_d, r1_d, wx1_d, rh2, hc2_d, dz3_d, h_out_d;
    ext_t sum4;

    always_comb begin
        z1_d    = hsig(sum3(qmul(sx(Wz), sx(X)), qmul(sx(Uz), sx(h_in)), bz));
        r1_d    = hsig(sum3(qmul(sx(Wr), sx(X)), qmul(sx(Ur), sx(h_in)), br));
        wx1_d   = qmul(sx(Wh), sx(X));
        rh2     = qmul(sx(r1_q), sx(h1_q));
        hc2_d   = htanh(sum3(wx1_q, qmul(sx(uh1_q), sx(rh2)), bh1_q));
        dz3_d   = qmul(sx(z2_q), sx(hc2_q) - sx(h2_q));
        sum4    = sx(h3_q) + sx(dz3_q);
        h_out_d = narrow({{(WW-DW-1){sum4[DW]}}, sum4});
    end

    // Each stage loads only with its valid bit, so captured operands are immune to later input changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_q <= '0;
            z1_q  <= '0; r1_q  <= '0; wx1_q <= '0;
            h1_q  <= '0; uh1_q <= '0; bh1_q <= '0;
            z2_q  <= '0; hc2_q <= '0; h2_q  <= '0;
            dz3_q <= '0; h3_q  <= '0;
            h_out_q <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[STAGES-1:0], in_valid};
            if (in_valid) begin
                z1_q  <= z1_d;
                r1_q  <= r1_d;
                wx1_q <= wx1_d;
                h1_q  <= h_in;
                uh1_q <= Uh;
                bh1_q <= bh;
            end
            if (vld_pipe_q[0]) begin
                z2_q  <= z1_q;
                hc2_q <= hc2_d;
                h2_q  <= h1_q;
            end
            if (vld_pipe_q[1]) begin
                dz3_q <= dz3_d;
                h3_q  <= h2_q;
            end
            if (vld_pipe_q[2]) h_out_q <= h_out_d;
        end
    end

    assign out_valid = vld_pipe_q[STAGES];
    assign h_out     = h_out_q;
endmodule

// File: tb/tb_gru_lstm_cell.sv
// Bench for gru_lstm_cell: directed corner cases, random back-to-back traffic and async reset,
// all against an integer model of the cell arithmetic.
module tb_gru_lstm_cell;
    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic signed [7:0] X, h_in, Wz, Wr, Wh, Uz, Ur, Uh, bz, br, bh;
    logic out_valid;
    logic signed [7:0] h_out;

    int checks = 0;
    int failures = 0;
    int qv[$];
    int qh[$];
    int last_h = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    gru_lstm_cell dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .X(X), .h_in(h_in),
        .Wz(Wz), .Wr(Wr), .Wh(Wh),
        .Uz(Uz), .Ur(Ur), .Uh(Uh),
        .bz(bz), .br(br), .bh(bh),
        .out_valid(out_valid), .h_out(h_out)
    );

    function automatic int nar(int v);
`ifdef GRU_LSTM_CELL_SAT_EN
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
`else
        int w;
        w = v & 255;
        return (w > 127) ? w - 256 : w;
`endif
    endfunction

    function automatic int qm(int a, int b);
        return nar((a * b) >>> 5);
    endfunction

    function automatic int hs(int x);
        int t;
        t = (x >>> 2) + 16;
        return (t < 0) ? 0 : (t > 32) ? 32 : t;
    endfunction

    function automatic int ht(int x);
        return (x < -32) ? -32 : (x > 32) ? 32 : x;
    endfunction

    function automatic int gru_ref(int x, int h, int wz, int wr, int wh, int uz, int ur, int uh,
                                   int vbz, int vbr, int vbh);
        int z, r, rh, hc;
        z  = hs(nar(qm(wz, x) + qm(uz, h) + vbz));
        r  = hs(nar(qm(wr, x) + qm(ur, h) + vbr));
        rh = qm(r, h);
        hc = ht(nar(qm(wh, x) + qm(uh, rh) + vbh));
        return nar(h + qm(z, hc - h));
    endfunction

    task automatic chk(string tag, logic [7:0] act, logic [7:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic setop(int x, int h, int wz, int wr, int wh, int uz, int ur, int uh,
                         int vbz, int vbr, int vbh);
        X = 8'(x); h_in = 8'(h); Wz = 8'(wz); Wr = 8'(wr); Wh = 8'(wh);
        Uz = 8'(uz); Ur = 8'(ur); Uh = 8'(uh); bz = 8'(vbz); br = 8'(vbr); bh = 8'(vbh);
    endtask

    task automatic randops();
        setop($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
              $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
              $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
              $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
              $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
              $urandom_range(0, 255) - 128);
    endtask

    // One clock: log what the DUT samples, then check what emerges three edges later.
    task automatic step();
        int v;
        int e;
        qv.push_back(int'(in_valid));
        qh.push_back(in_valid ? gru_ref(int'(X), int'(h_in), int'(Wz), int'(Wr), int'(Wh),
                                        int'(Uz), int'(Ur), int'(Uh), int'(bz), int'(br), int'(bh)) : 0);
        @(posedge clk);
        #1;
        v = 0;
        if (qv.size() == 4) begin
            v = qv.pop_front();
            e = qh.pop_front();
            if (v != 0) last_h = e;
        end
        if (out_valid === 1'b1) pulses++;
        chk("sb_out_valid", {7'b0, out_valid}, 8'(v));
        chk("sb_h_out", h_out, 8'(last_h));
    endtask

    task automatic directed(string tag, int x, int h, int wz, int wr, int wh, int uz, int ur,
                            int uh, int vbz, int vbr, int vbh, logic [7:0] exp);
        setop(x, h, wz, wr, wh, uz, ur, uh, vbz, vbr, vbh);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        randops();
        repeat (3) step();
        chk({tag, "_valid"}, {7'b0, out_valid}, 8'd1);
        chk(tag, h_out, exp);
    endtask

    initial begin
        logic [7:0] ovf_exp;
        rst = 1'b1;
        in_valid = 1'b0;
        setop(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_h_out", h_out, 8'd0);
        chk("reset_out_valid", {7'b0, out_valid}, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        directed("decay", 0, 32, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd16);
        directed("all_zero", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
        directed("gate_sat", 0, 0, 0, 0, 0, 0, 0, 0, 127, 0, 64, 8'd32);
`ifdef GRU_LSTM_CELL_SAT_EN
        ovf_exp = 8'd32;
`else
        ovf_exp = 8'hF8;
`endif
        directed("overflow", 127, 0, 0, 0, 127, 0, 0, 0, 127, 0, 0, ovf_exp);

        pulses = 0;
        in_valid = 1'b1;
        repeat (20) begin
            randops();
            step();
        end
        in_valid = 1'b0;
        repeat (3) begin
            randops();
            step();
        end
        chk("tput_pulses", 8'(pulses), 8'd20);

        in_valid = 1'b1;
        repeat (2) begin
            randops();
            step();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_h_out", h_out, 8'd0);
        chk("midrst_out_valid", {7'b0, out_valid}, 8'd0);
        qv.delete();
        qh.delete();
        last_h = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        repeat (4) begin
            randops();
            step();
        end
        chk("no_stale_valid", 8'(pulses), 8'd0);
        directed("post_rst", 0, 32, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gru_lstm_cell.md
GRU_LSTM_CELL -- requirements
Module: gru_lstm_cell

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of every data port.
REQ-002 SHALL have parameter FRACT_WIDTH, default 5: fractional bits; all data is signed two's-complement Q2.5, where 1.0 = 32.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand set is valid this cycle.
REQ-006 SHALL have port X, input, DATA_WIDTH bits: input sample.
REQ-007 SHALL have port h_in, input, DATA_WIDTH bits: previous hidden state.
REQ-008 SHALL have ports Wz, Wr, Wh, input, DATA_WIDTH bits each: input weights for the update, reset and candidate paths.
REQ-009 SHALL have ports Uz, Ur, Uh, input, DATA_WIDTH bits each: recurrent weights for the same three paths.
REQ-010 SHALL have ports bz, br, bh, input, DATA_WIDTH bits each: biases for the same three paths.
REQ-011 SHALL have port out_valid, output, 1 bit: h_out holds a new result this cycle.
REQ-012 SHALL have port h_out, output, DATA_WIDTH bits, signed: new hidden state.

Function
REQ-013 SHALL define the multiply q(a,b) as the full signed product arithmetic-shifted right by FRACT_WIDTH (floor), then narrowed to DATA_WIDTH bits per REQ-020.
REQ-014 SHALL compute each three-term sum (q + q + bias) at DATA_WIDTH+2 bits, then narrow it per REQ-020.
REQ-015 SHALL compute sig(x) = (x >>> 2) + 16, clamped to [0,32]; this is a hard sigmoid.
REQ-016 SHALL compute tanh(x) = x clamped to [-32,32]; this is a hard tanh.
REQ-017 SHALL compute the gates and candidate as follows:
- z = sig(q(Wz,X) + q(Uz,h_in) + bz)
- r = sig(q(Wr,X) + q(Ur,h_in) + br)
- rh = q(r,h_in)
- hc = tanh(q(Wh,X) + q(Uh,rh) + bh)
REQ-018 SHALL compute h_out = h_in + q(z, hc - h_in), where hc - h_in is held at DATA_WIDTH+1 bits and the final add is narrowed per REQ-020.
REQ-019 SHALL be fully pipelined with fixed latency 3:
- an operand set sampled with in_valid=1 at rising edge N appears on h_out with out_valid=1 after edge N+3;
- one result per cycle;
- no stall or backpressure.
REQ-020 SHALL narrow values by saturation to [-128,127] when GRU_LSTM_CELL_SAT_EN is defined; otherwise it SHALL keep the low DATA_WIDTH bits (wrap).
REQ-021 SHALL propagate out_valid=0 for cycles whose in_valid=0, and SHALL hold h_out at its last value on those cycles.
REQ-022 SHALL use only the operands captured at the in_valid edge to compute a result; input changes after that edge SHALL NOT affect it.

Reset
REQ-023 SHALL, while rst=1, immediately force h_out=0, out_valid=0 and every pipeline valid bit to 0, independent of clk.
REQ-024 SHALL discard any operations in flight at reset; the first out_valid after reset release SHALL be for an input sampled after release.

Configuration
REQ-025 SHALL select the narrowing mode with macro GRU_LSTM_CELL_SAT_EN:
- defined: saturating arithmetic;
- undefined: wrap-around arithmetic.
The port list and latency SHALL be identical in both modes.

Verification
REQ-026 SHALL check the all-zero case: all inputs 0, in_valid=1 -> after 3 cycles h_out=0 (z=16, hc=0), out_valid=1.
REQ-027 SHALL check state decay: h_in=32, all else 0 -> h_out=16 (0.5).
REQ-028 SHALL check gate saturation: bz=127 (z=32), bh=64 (hc clamps to 32), h_in=0, all else 0 -> h_out=32.
REQ-029 SHALL check overflow with X=127, Wh=127, bz=127, all else 0:
- with GRU_LSTM_CELL_SAT_EN defined -> h_out=32;
- without it -> product wraps to -8, h_out=-8 (0xF8).
REQ-030 SHALL check throughput: random operands with in_valid=1 on 20 consecutive cycles -> 20 consecutive out_valid pulses, each matching a bit-exact reference model of REQ-013..REQ-020 at 3-cycle offset.
REQ-031 SHALL check reset mid-operation: assert rst asynchronously with 2 operations in flight -> h_out=0 and out_valid=0 immediately; no stale out_valid after release.
